// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared types for the CPU instruction/data memory arbiter.
package cpu_mem_arbiter_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_REQ  = 3'b010,
    ST_RESP = 3'b100
  } arb_state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

endpackage

// File: rtl/cpu_mem_arbiter_if.sv
// Bundle of the fetch, load/store and unified memory channels around the arbiter.
interface cpu_mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_req_valid;
  logic              inst_req_ready;
  logic [31:0]       inst_rdata;
  logic              inst_rvalid;
  logic              inst_rready;

  logic [ADDR_W-1:0] data_addr;
  logic              data_wen;
  logic              data_ren;
  logic [31:0]       data_wdata;
  logic [3:0]        data_wstrb;
  logic              data_req_ready;
  logic [31:0]       data_rdata;
  logic              data_rvalid;
  logic              data_rready;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_req_valid;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_req_ready;
  logic [31:0]       mem_rdata;
  logic              mem_rvalid;
  logic              mem_rready;

  // Arbiter side.
  modport slave (
    input  inst_addr, inst_req_valid, inst_rready,
    input  data_addr, data_wen, data_ren, data_wdata, data_wstrb, data_rready,
    input  mem_req_ready, mem_rdata, mem_rvalid,
    output inst_req_ready, inst_rdata, inst_rvalid,
    output data_req_ready, data_rdata, data_rvalid,
    output mem_addr, mem_req_valid, mem_we, mem_wdata, mem_wstrb, mem_rready
  );

  // CPU plus memory side.
  modport master (
    output inst_addr, inst_req_valid, inst_rready,
    output data_addr, data_wen, data_ren, data_wdata, data_wstrb, data_rready,
    output mem_req_ready, mem_rdata, mem_rvalid,
    input  inst_req_ready, inst_rdata, inst_rvalid,
    input  data_req_ready, data_rdata, data_rvalid,
    input  mem_addr, mem_req_valid, mem_we, mem_wdata, mem_wstrb, mem_rready
  );

endinterface

// File: rtl/cpu_mem_arbiter_perf_cnt.sv
// Wrapping statistics counter with enable, exported to spare perf-counter slots.
module cpu_mem_arbiter_perf_cnt
  import cpu_mem_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Shares one memory port between instruction fetch and data load/store,
// one transaction outstanding, with grant/conflict statistics.
module cpu_mem_arbiter
  import cpu_mem_arbiter_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b0,
  parameter int ADDR_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  cpu_mem_arbiter_if.slave bus,
  output logic [CNT_W-1:0] inst_grant_cnt,
  output logic [CNT_W-1:0] data_grant_cnt,
  output logic [CNT_W-1:0] conflict_cnt
);

  arb_state_t        state, state_next;
  owner_t            owner, owner_next;
  owner_t            rr_last, rr_last_next;
  logic              pend_i, pend_d;
  logic              accept;
  logic              rready_sel;
  logic [ADDR_W-1:0] addr_sel;

  assign pend_i = bus.inst_req_valid;
  assign pend_d = bus.data_wen | bus.data_ren;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      owner   <= OWN_INST;
      rr_last <= OWN_INST;
    end else begin
      state   <= state_next;
      owner   <= owner_next;
      rr_last <= rr_last_next;
    end
  end

  always_comb begin
    state_next         = state;
    owner_next         = owner;
    rr_last_next       = rr_last;
    accept             = 1'b0;
    rready_sel         = 1'b0;
    addr_sel           = '0;
    bus.mem_req_valid  = 1'b0;
    bus.mem_we         = 1'b0;
    bus.mem_wdata      = '0;
    bus.mem_wstrb      = '0;
    bus.mem_rready     = 1'b0;
    bus.inst_req_ready = 1'b0;
    bus.inst_rdata     = '0;
    bus.inst_rvalid    = 1'b0;
    bus.data_req_ready = 1'b0;
    bus.data_rdata     = '0;
    bus.data_rvalid    = 1'b0;

    case (state)
      ST_IDLE: begin
        // Owner is latched here; the request goes out next cycle.
        if (pend_i | pend_d) begin
          state_next = ST_REQ;
          if (pend_i & pend_d)
            owner_next = (ROUND_ROBIN && rr_last == OWN_DATA) ? OWN_INST : OWN_DATA;
          else
            owner_next = pend_d ? OWN_DATA : OWN_INST;
        end
      end

      ST_REQ: begin
        bus.mem_req_valid = 1'b1;
        if (owner == OWN_DATA) begin
          addr_sel           = bus.data_addr;
          bus.mem_we         = bus.data_wen;
          bus.mem_wdata      = bus.data_wdata;
          bus.mem_wstrb      = bus.data_wstrb;
          bus.data_req_ready = bus.mem_req_ready;
        end else begin
          addr_sel           = bus.inst_addr;
          bus.inst_req_ready = bus.mem_req_ready;
        end
        if (bus.mem_req_ready) begin
          accept       = 1'b1;
          rr_last_next = owner;
          // Stores carry no response, so they skip RESP.
          state_next   = (owner == OWN_DATA && bus.data_wen) ? ST_IDLE : ST_RESP;
        end
      end

      ST_RESP: begin
        if (owner == OWN_DATA) begin
          rready_sel      = bus.data_rready;
          bus.data_rvalid = bus.mem_rvalid;
          bus.data_rdata  = bus.mem_rdata;
        end else begin
          rready_sel      = bus.inst_rready;
          bus.inst_rvalid = bus.mem_rvalid;
          bus.inst_rdata  = bus.mem_rdata;
        end
        bus.mem_rready = rready_sel;
        if (bus.mem_rvalid && rready_sel) state_next = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.mem_addr = addr_sel;

  cpu_mem_arbiter_perf_cnt u_inst_cnt (
    .clk (clk),
    .rst (rst),
    .en  (accept && owner == OWN_INST),
    .cnt (inst_grant_cnt)
  );

  cpu_mem_arbiter_perf_cnt u_data_cnt (
    .clk (clk),
    .rst (rst),
    .en  (accept && owner == OWN_DATA),
    .cnt (data_grant_cnt)
  );

  cpu_mem_arbiter_perf_cnt u_conflict_cnt (
    .clk (clk),
    .rst (rst),
    .en  (state == ST_IDLE && pend_i && pend_d),
    .cnt (conflict_cnt)
  );

endmodule

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
Shares one unified memory port between the multicycle CPU's instruction-fetch channel and its data load/store channel. It keeps one transaction outstanding at a time. Request and response handshakes are routed to the granted requester, and grant/stall statistics are exported to spare cpu_perf_cnt slots. It sits between custom_cpu and the memory/AXI bridge.

Parameters:
ROUND_ROBIN, 0, 0 = fixed priority (data over inst); 1 = alternate the winner on simultaneous requests
ADDR_W, 32, address width of all channels

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
inst_addr  in  ADDR_W  fetch address (CPU PC)
inst_req_valid  in  1  fetch request
inst_req_ready  out  1  fetch request accepted
inst_rdata  out  32  fetched instruction
inst_rvalid  out  1  instruction response valid
inst_rready  in  1  CPU ready for instruction
data_addr  in  ADDR_W  word-aligned load/store address
data_wen  in  1  store request (MemWrite)
data_ren  in  1  load request (MemRead)
data_wdata  in  32  store data
data_wstrb  in  4  store byte strobes
data_req_ready  out  1  load/store accepted
data_rdata  out  32  load data
data_rvalid  out  1  load response valid
data_rready  in  1  CPU ready for load data
mem_addr  out  ADDR_W  unified request address
mem_req_valid  out  1  unified request valid
mem_we  out  1  1 = write, 0 = read
mem_wdata  out  32  write data
mem_wstrb  out  4  write strobes
mem_req_ready  in  1  memory accepted request
mem_rdata  in  32  read data
mem_rvalid  in  1  read data valid
mem_rready  out  1  arbiter ready for read data
inst_grant_cnt  out  32  accepted fetches
data_grant_cnt  out  32  accepted loads + stores
conflict_cnt  out  32  cycles in IDLE with both requesters pending

Behaviour:
- Clock and reset: clk only; rst is asynchronous, active-high. On reset: state=IDLE, owner=INST, rr_last=INST, all counters 0, and every output valid/ready/we = 0. Data and address outputs are 0 when not granted.
- State machine: IDLE, REQ, RESP.
- IDLE: pending_i = inst_req_valid; pending_d = data_wen | data_ren.
  - Neither pending: stay in IDLE.
  - One pending: latch that owner.
  - Both pending: latch DATA if ROUND_ROBIN=0. If ROUND_ROBIN=1, latch the requester opposite rr_last.
  - Whenever an owner is latched: go to REQ next cycle (one-cycle arbitration bubble). No upstream ready is asserted in IDLE.
- REQ: owner's request fields are forwarded combinationally to the mem_* request signals, with mem_req_valid=1.
  - mem_we = data_wen when owner=DATA; mem_we = 0 when owner=INST.
  - Owner's req_ready = mem_req_ready. The non-owner's ready = 0.
  - On mem_req_ready: increment the owner's grant counter and update rr_last=owner. Then go to IDLE for a write, otherwise to RESP.
  - Otherwise hold REQ. Requesters must keep fields stable until accepted.
- RESP: mem_rready = owner's rready. Owner's rvalid = mem_rvalid and owner's rdata = mem_rdata; non-owner rvalid = 0.
  - On mem_rvalid & mem_rready: go to IDLE.
- Minimum latency: request seen in IDLE → mem_req_valid next cycle → accepted same cycle as mem_req_ready. Read response is passed through with zero added latency.
- If data_wen and data_ren are both high, it is treated as a write. Such a request is illegal; the bench flags it as an assertion.
- conflict_cnt increments in IDLE when pending_i & pending_d.
- All counters are 32-bit and wrap from 0xFFFFFFFF to 0.
- An owner dropping its valid in REQ without acceptance is illegal. The arbiter still holds REQ (request is forwarded as sampled).
- mem_rvalid arriving in IDLE/REQ is ignored. mem_rready=0 there.
- Reset mid-transaction: returns to IDLE immediately. The in-flight memory response is not tracked; system reset covers memory too.

Decomposition:
- Shared package (cpu_defs): state encoding (IDLE/REQ/RESP, one-hot 3-bit), owner encoding (INST=0, DATA=1), counter width constant.
- Natural sub-module: arb_perf_cnt, a 32-bit wrapping counter with async reset and enable, instantiated three times.

Test Plan:
- Fetch only: inst_req_valid=1, addr 0x100; memory ready after 2 cycles, returns 0x00000013 after 3 → mem_req_valid rises cycle 1, inst_req_ready pulses once, inst_rvalid with 0x13, inst_grant_cnt=1.
- Store only: data_wen=1, addr 0x204, wdata 0xDEADBEEF, wstrb 0xF → mem_we=1 with the same fields, data_req_ready pulse, state back to IDLE without RESP, data_grant_cnt=1.
- Simultaneous fetch and load, ROUND_ROBIN=0 → data granted first, inst second; conflict_cnt=1; inst_rvalid never asserted during the data response.
- ROUND_ROBIN=1, five back-to-back simultaneous requests → winners alternate D,I,D,I,D (rr_last initialised to INST).
- Backpressure: mem_rvalid=1 while data_rready=0 for 4 cycles → mem_rready=0 and state holds RESP; completes on the cycle data_rready=1.
- Async rst asserted mid-REQ between clock edges → mem_req_valid drops before the next edge, all counters read 0, first post-reset request is served normally.
